// File: rtl/mc_control_fsm_if.sv
// Shared instruction/data memory handshake between the multi-cycle controller and memory.
interface mc_control_fsm_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack;
  logic [XLEN-1:0] instr;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ack,
    input  instr
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ack,
    output instr
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake, retire counting and sticky halt on illegal opcode or bus timeout.
module mc_control_fsm #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   mem,
  input  logic               alu_zero_i,
  output logic [31:0]        ir_o,
  output logic               pc_we_o,
  output logic               pc_src_o,
  output logic               reg_we_o,
  output logic               alu_src_o,
  output logic [1:0]         alu_op_o,
  output logic [1:0]         wb_sel_o,
  output logic [2:0]         state_o,
  output logic               retire_o,
  output logic [CNT_W-1:0]   instr_count_o,
  output logic               illegal_o,
  output logic               bus_err_o
);

  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [2:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic       mem_req_c, mem_we_c, pc_we_c, pc_src_c, reg_we_c, alu_src_c, retire_c;
  logic [1:0] alu_op_c, wb_sel_c;

  // Instruction-class decode of the latched IR
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_legal;
  logic       timeout_hit, ack_ok;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_legal  = is_r | is_i | is_load | is_store | is_jal
                   | (is_branch & (funct3[2:1] == 2'b00));

  // An ack arriving once the counter has reached TIMEOUT is already too late
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));
  assign ack_ok      = mem.mem_ack & ~timeout_hit;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    wait_d    = '0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    pc_we_c   = 1'b0;
    pc_src_c  = 1'b0;
    reg_we_c  = 1'b0;
    alu_src_c = 1'b0;
    alu_op_c  = 2'b00;
    wb_sel_c  = 2'b00;
    retire_c  = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else if (ack_ok) begin
          ir_d    = mem.instr[31:0];
          state_d = DECODE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        if (!is_legal) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_src_c = is_i | is_load | is_store;
        alu_op_c  = (is_r | is_i) ? 2'b10 : (is_branch ? 2'b01 : 2'b00);
        if (is_branch) begin
          pc_we_c  = 1'b1;
          pc_src_c = alu_zero_i ^ funct3[0];
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        alu_src_c = 1'b1;
        alu_op_c  = 2'b00;
        if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else if (ack_ok) begin
          if (is_store) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WB: begin
        reg_we_c = (ir_q[11:7] != 5'd0);
        wb_sel_c = is_load ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
        pc_we_c  = 1'b1;
        pc_src_c = is_jal;
        retire_c = 1'b1;
        state_d  = FETCH;
      end
      HALT: ;
      default: state_d = HALT;
    endcase

    if (retire_c) cnt_d = cnt_q + CNT_W'(1);

    // No strobe may leak out while reset is asserted, whatever state we were in
    if (rst) begin
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      pc_we_c   = 1'b0;
      reg_we_c  = 1'b0;
      retire_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
    end
  end

  assign mem.mem_req    = mem_req_c;
  assign mem.mem_we     = mem_we_c;
  assign ir_o           = ir_q;
  assign pc_we_o        = pc_we_c;
  assign pc_src_o       = pc_src_c;
  assign reg_we_o       = reg_we_c;
  assign alu_src_o      = alu_src_c;
  assign alu_op_o       = alu_op_c;
  assign wb_sel_o       = wb_sel_c;
  assign state_o        = state_q;
  assign retire_o       = retire_c;
  assign instr_count_o  = cnt_q;
  assign illegal_o      = illegal_q;
  assign bus_err_o      = bus_err_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode controller.
- Sequences each RV32I-subset instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with a shared instruction/data memory and latches the instruction register.
- Drives datapath controls (PC, register file, ALU, memory), counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
XLEN, 32, instruction/data width; only bits [31:0] of instr are decoded.
CNT_W, 32, width of the retired-instruction counter.
TIMEOUT, 15, maximum wait cycles for mem_ack; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
mem_ack  in  1  memory completes the current access this cycle
instr  in  XLEN  memory read data, captured as instruction in FETCH
alu_zero  in  1  ALU result == 0, from the datapath
mem_req  out  1  memory access request
mem_we  out  1  store (1) / read (0); valid only with mem_req
ir  out  32  latched instruction register
pc_we  out  1  PC update strobe
pc_src  out  1  0 = PC+4, 1 = branch/JAL target
reg_we  out  1  register-file write strobe
alu_src  out  1  0 = rs2, 1 = imm32
alu_op  out  2  00 add (addr), 01 sub (branch), 10 funct-decoded
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
retire  out  1  one-cycle pulse per completed instruction
instr_count  out  CNT_W  retired-instruction count
illegal  out  1  sticky: halted on an unsupported opcode
bus_err  out  1  sticky: halted on a memory timeout

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-access):
  - state=FETCH, ir=0, instr_count=0, illegal=0, bus_err=0, wait counter=0.
  - All strobes are 0 during the reset cycle.
- Outputs are Moore-style: decoded from state and ir, never from instr.
- Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (funct3 000 BEQ, 001 BNE only), JAL 1101111.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ack: ir<=instr[31:0], go to DECODE.
  - Without ack: stay, and the wait counter increments.
- DECODE:
  - Unsupported opcode, or BRANCH with funct3 not in {000,001}: illegal<=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC controls:
  - alu_src=1 for I/LOAD/STORE, 0 otherwise.
  - alu_op = 10 for R/I, 00 for LOAD/STORE, 01 for BRANCH.
- EXEC transitions:
  - R/I/JAL go to WB.
  - LOAD/STORE go to MEM.
  - BRANCH: pc_we=1, pc_src = alu_zero XOR funct3[0], retire=1, go to FETCH.
- MEM:
  - mem_req=1, mem_we = (STORE); alu_op and alu_src are held at their EXEC values.
  - On ack, LOAD goes to WB.
  - On ack, STORE asserts pc_we=1, pc_src=0, retire=1 and goes to FETCH.
- WB:
  - reg_we = (ir[11:7] != 0).
  - wb_sel = 01 for LOAD, 10 for JAL, 00 otherwise.
  - pc_we=1, pc_src = (JAL), retire=1, go to FETCH.
- Latencies with zero-wait memory: BRANCH 3 cycles; R, I, JAL, STORE 4; LOAD 5. Each cycle without ack adds 1.
- Wait counter:
  - Clears on entering FETCH or MEM, and on ack.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT with no ack: bus_err<=1, go to HALT. Exactly TIMEOUT non-ack cycles are tolerated; ack on cycle TIMEOUT+1 is too late.
- mem_ack outside FETCH/MEM is ignored.
- instr_count increments on every retire and wraps modulo 2^CNT_W.
- HALT:
  - All strobes are 0; ir, instr_count and the flags hold.
  - Only rst exits HALT.

Test Plan:
- Reset: hold rst 2 cycles, release -> state=0, mem_req=1, mem_we=0, instr_count=0, illegal=0, bus_err=0.
- ADD x3,x1,x2 (0x002081B3), zero-wait ack:
  - state sequence 0,1,2,4; alu_op=10 in EXEC.
  - In WB: reg_we=1, wb_sel=00, pc_we=1, pc_src=0, retire=1; instr_count=1.
- LW x5,4(x1) (0x0040A283), ack withheld 3 cycles in MEM:
  - mem_req stays 1, mem_we=0 throughout MEM.
  - WB occurs with wb_sel=01, reg_we=1; total 8 cycles.
- BNE (0x00209463):
  - with alu_zero=0 -> EXEC asserts pc_we=1, pc_src=1, retire=1, next state FETCH.
  - repeat with alu_zero=1 -> pc_src=0.
- Fault and recovery:
  - ir=0xFFFFFFFF -> HALT, illegal=1, strobes 0 for 20 cycles.
  - Separately, TIMEOUT=15 with no ack in FETCH -> bus_err=1 after 15 wait cycles.
  - rst clears both flags.
- Reset mid-MEM during a STORE (0x0020A223): mem_req drops the same edge, state=0, instr_count unchanged from 0, no retire pulse.
